// File: rtl/sg32_isa_pkg.sv
// -----------------------------------------------------------------------------
// sg32_isa_pkg
// Shared SG32 instruction-set constants: class codes, immediate-slot modes,
// instruction field positions and the immediate width.
// -----------------------------------------------------------------------------
package sg32_isa_pkg;

    localparam int INSTR_W     = 32;
    localparam int IMM_W       = 12;

    // field positions within the 32-bit instruction word
    localparam int CLS_LSB     = 0;
    localparam int CLS_W       = 2;
    localparam int MODE_LSB    = 2;
    localparam int MODE_W      = 2;
    localparam int OPC_LSB     = 4;
    localparam int OPC_W       = 6;
    localparam int F1_LSB      = 10;
    localparam int F2_LSB      = 15;
    localparam int F3_LSB      = 20;
    localparam int REG_FIELD_W = 5;
    localparam int IMM_LSB     = 20;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'b00,
        CLS_RAM  = 2'b01,
        CLS_COND = 2'b10,
        CLS_EXT  = 2'b11
    } cls_e;

    // which operand slot carries the immediate
    typedef enum logic [1:0] {
        IMM_NONE = 2'b00,
        IMM_A    = 2'b01,
        IMM_B    = 2'b10,
        IMM_C    = 2'b11
    } imm_mode_e;

endpackage

// File: rtl/decode_fields.sv
// -----------------------------------------------------------------------------
// decode_fields
// Purely combinational SG32 field decode.
//
// Parameters: XLEN (immediate width), NREG (register count, power of 2),
//             IMM_SIGNED (1 = sign-extend immediate, 0 = zero-extend)
// Ports:
//   instr                               instruction word
//   alu_en/ram_en/cond_en/ext_en        one-hot class
//   opcode, imm_mode                    raw opcode and immediate-slot mode
//   a_en/b_en/c_en                      one-hot register enables (0 for imm/ext)
//   a_imm/b_imm/c_imm                   slot carries the immediate
//   imm                                 extended immediate, always driven
// -----------------------------------------------------------------------------
module decode_fields
    import sg32_isa_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int IMM_SIGNED = 1
) (
    input  logic [INSTR_W-1:0] instr,
    output logic               alu_en,
    output logic               ram_en,
    output logic               cond_en,
    output logic               ext_en,
    output logic [OPC_W-1:0]   opcode,
    output logic [MODE_W-1:0]  imm_mode,
    output logic [NREG-1:0]    a_en,
    output logic [NREG-1:0]    b_en,
    output logic [NREG-1:0]    c_en,
    output logic               a_imm,
    output logic               b_imm,
    output logic               c_imm,
    output logic [XLEN-1:0]    imm
);

    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

    // only the low RW bits of a register field select a register
    function automatic logic [NREG-1:0] onehot(input logic [RW-1:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    cls_e             cls;
    logic [RW-1:0]    f1;
    logic [RW-1:0]    f2;
    logic [RW-1:0]    f3;
    logic [IMM_W-1:0] imm12;
    logic             unused_instr;

    assign cls          = cls_e'(instr[CLS_LSB +: CLS_W]);
    assign f1           = instr[F1_LSB +: RW];
    assign f2           = instr[F2_LSB +: RW];
    assign f3           = instr[F3_LSB +: RW];
    assign imm12        = instr[IMM_LSB +: IMM_W];
    assign opcode       = instr[OPC_LSB +: OPC_W];
    assign imm_mode     = instr[MODE_LSB +: MODE_W];
    assign unused_instr = ^instr;

    assign alu_en  = (cls == CLS_ALU);
    assign ram_en  = (cls == CLS_RAM);
    assign cond_en = (cls == CLS_COND);
    assign ext_en  = (cls == CLS_EXT);

    generate
        if (IMM_SIGNED != 0) begin : g_sext
            assign imm = XLEN'($signed(imm12));
        end else begin : g_zext
            assign imm = XLEN'(imm12);
        end
    endgenerate

    // register fields fill the non-immediate slots in A, B, C order
    always_comb begin
        a_en  = '0;
        b_en  = '0;
        c_en  = '0;
        a_imm = 1'b0;
        b_imm = 1'b0;
        c_imm = 1'b0;
        case (imm_mode_e'(imm_mode))
            IMM_NONE: begin
                a_en = onehot(f1);
                b_en = onehot(f2);
                c_en = onehot(f3);
            end
            IMM_A: begin
                a_imm = 1'b1;
                b_en  = onehot(f1);
                c_en  = onehot(f2);
            end
            IMM_B: begin
                a_en  = onehot(f1);
                b_imm = 1'b1;
                c_en  = onehot(f2);
            end
            default: begin
                a_en  = onehot(f1);
                b_en  = onehot(f2);
                c_imm = 1'b1;
            end
        endcase
        // extension-class words carry no register operands at all
        if (cls == CLS_EXT) begin
            a_en  = '0;
            b_en  = '0;
            c_en  = '0;
            a_imm = 1'b0;
            b_imm = 1'b0;
            c_imm = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// One-deep registered decode stage with valid/ready handshake and an optional
// register scoreboard interlock (compile with DECODE_SCOREBOARD_EN to enable).
//
// Parameters: XLEN, NREG, IMM_SIGNED (see decode_fields)
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_instr/in_ready    instruction input handshake
//   out_valid/out_ready           decoded bundle handshake
//   out_*                         registered decoded bundle
//   wb_valid/wb_reg               writeback retiring a register
//   flush                         discard the held bundle
//   sb_busy                       pending-write bits (0 without scoreboard)
// -----------------------------------------------------------------------------
module decode_stage
    import sg32_isa_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int IMM_SIGNED = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [31:0]        in_instr,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_alu_en,
    output logic               out_ram_en,
    output logic               out_cond_en,
    output logic               out_ext_en,
    output logic [5:0]         out_opcode,
    output logic [1:0]         out_imm_mode,
    output logic [NREG-1:0]    out_a_en,
    output logic [NREG-1:0]    out_b_en,
    output logic [NREG-1:0]    out_c_en,
    output logic               out_a_imm,
    output logic               out_b_imm,
    output logic               out_c_imm,
    output logic [XLEN-1:0]    out_imm,
    input  logic               wb_valid,
    input  logic [4:0]         wb_reg,
    input  logic               flush,
    output logic [NREG-1:0]    sb_busy
);

    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

    logic            dec_alu_en;
    logic            dec_ram_en;
    logic            dec_cond_en;
    logic            dec_ext_en;
    logic [5:0]      dec_opcode;
    logic [1:0]      dec_imm_mode;
    logic [NREG-1:0] dec_a_en;
    logic [NREG-1:0] dec_b_en;
    logic [NREG-1:0] dec_c_en;
    logic            dec_a_imm;
    logic            dec_b_imm;
    logic            dec_c_imm;
    logic [XLEN-1:0] dec_imm;
    logic            hazard;
    logic            accept;

    decode_fields #(
        .XLEN       (XLEN),
        .NREG       (NREG),
        .IMM_SIGNED (IMM_SIGNED)
    ) u_fields (
        .instr    (in_instr),
        .alu_en   (dec_alu_en),
        .ram_en   (dec_ram_en),
        .cond_en  (dec_cond_en),
        .ext_en   (dec_ext_en),
        .opcode   (dec_opcode),
        .imm_mode (dec_imm_mode),
        .a_en     (dec_a_en),
        .b_en     (dec_b_en),
        .c_en     (dec_c_en),
        .a_imm    (dec_a_imm),
        .b_imm    (dec_b_imm),
        .c_imm    (dec_c_imm),
        .imm      (dec_imm)
    );

    assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef DECODE_SCOREBOARD_EN
    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_next;
    logic [RW-1:0]   wb_idx;
    logic            unused_wb;

    assign wb_idx    = wb_reg[RW-1:0];
    assign unused_wb = ^wb_reg;
    assign sb_busy   = sb_q;

    // imm and ext slots decode to all-zero enables, so they never match
    assign hazard = in_valid && (|((dec_a_en | dec_b_en) & sb_q));

    // the set is applied last so a same-cycle set and clear leaves it set
    always_comb begin
        sb_next = sb_q;
        if (wb_valid) begin
            sb_next[wb_idx] = 1'b0;
        end
        if (flush && out_valid) begin
            sb_next = sb_next & ~out_c_en;
        end
        if (accept) begin
            sb_next = sb_next | dec_c_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_next;
        end
    end
`else
    logic unused_wb;

    assign unused_wb = wb_valid ^ (^wb_reg);
    assign hazard    = 1'b0;
    assign sb_busy   = '0;
`endif

    // bundle fields only change on a load; flush and drain just drop valid
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_alu_en   <= 1'b0;
            out_ram_en   <= 1'b0;
            out_cond_en  <= 1'b0;
            out_ext_en   <= 1'b0;
            out_opcode   <= '0;
            out_imm_mode <= '0;
            out_a_en     <= '0;
            out_b_en     <= '0;
            out_c_en     <= '0;
            out_a_imm    <= 1'b0;
            out_b_imm    <= 1'b0;
            out_c_imm    <= 1'b0;
            out_imm      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_alu_en   <= dec_alu_en;
            out_ram_en   <= dec_ram_en;
            out_cond_en  <= dec_cond_en;
            out_ext_en   <= dec_ext_en;
            out_opcode   <= dec_opcode;
            out_imm_mode <= dec_imm_mode;
            out_a_en     <= dec_a_en;
            out_b_en     <= dec_b_en;
            out_c_en     <= dec_c_en;
            out_a_imm    <= dec_a_imm;
            out_b_imm    <= dec_b_imm;
            out_c_imm    <= dec_c_imm;
            out_imm      <= dec_imm;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Directed and randomized checks of decode_stage against a behavioural model.
// Two instances share the stimulus: sign-extending and zero-extending.
// Scoreboard expectations follow DECODE_SCOREBOARD_EN as compiled.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int XLEN = 32;
    localparam int NREG = 32;
`ifdef DECODE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, in_valid, out_ready, wb_valid, flush;
    logic [31:0] in_instr;
    logic [4:0]  wb_reg;

    logic in_ready, out_valid, out_alu_en, out_ram_en, out_cond_en, out_ext_en;
    logic [5:0] out_opcode;
    logic [1:0] out_imm_mode;
    logic [NREG-1:0] out_a_en, out_b_en, out_c_en, sb_busy;
    logic out_a_imm, out_b_imm, out_c_imm;
    logic [XLEN-1:0] out_imm;

    logic zx_in_ready, zx_out_valid, zx_alu, zx_ram, zx_cond, zx_ext;
    logic [5:0] zx_opcode;
    logic [1:0] zx_imm_mode;
    logic [NREG-1:0] zx_a_en, zx_b_en, zx_c_en, zx_sb_busy;
    logic zx_a_imm, zx_b_imm, zx_c_imm;
    logic [XLEN-1:0] zx_imm;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .NREG(NREG), .IMM_SIGNED(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_en(out_alu_en), .out_ram_en(out_ram_en),
        .out_cond_en(out_cond_en), .out_ext_en(out_ext_en),
        .out_opcode(out_opcode), .out_imm_mode(out_imm_mode),
        .out_a_en(out_a_en), .out_b_en(out_b_en), .out_c_en(out_c_en),
        .out_a_imm(out_a_imm), .out_b_imm(out_b_imm), .out_c_imm(out_c_imm),
        .out_imm(out_imm), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .flush(flush), .sb_busy(sb_busy)
    );

    decode_stage #(.XLEN(XLEN), .NREG(NREG), .IMM_SIGNED(0)) u_zx (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(zx_in_ready), .out_valid(zx_out_valid), .out_ready(out_ready),
        .out_alu_en(zx_alu), .out_ram_en(zx_ram),
        .out_cond_en(zx_cond), .out_ext_en(zx_ext),
        .out_opcode(zx_opcode), .out_imm_mode(zx_imm_mode),
        .out_a_en(zx_a_en), .out_b_en(zx_b_en), .out_c_en(zx_c_en),
        .out_a_imm(zx_a_imm), .out_b_imm(zx_b_imm), .out_c_imm(zx_c_imm),
        .out_imm(zx_imm), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .flush(flush), .sb_busy(zx_sb_busy)
    );

    // expected decoded bundle; slot index 0/1/2 = A/B/C
    typedef struct packed {
        logic [3:0]       cls;
        logic [5:0]       opcode;
        logic [1:0]       mode;
        logic [2:0][31:0] en;
        logic [2:0]       immf;
        logic [31:0]      imm;
        logic [31:0]      immz;
    } bundle_t;

    bit          m_valid = 1'b0;
    bundle_t     m_b     = '0;
    logic [31:0] m_busy  = '0;

    function automatic bundle_t model_decode(input logic [31:0] instr);
        bundle_t b;
        int cls, mode, n, imm12;
        int fld[3];
        int slot[3];
        b     = '0;
        cls   = int'(instr % 4);
        mode  = int'((instr >> 2) % 4);
        b.cls[cls] = 1'b1;
        b.opcode   = 6'((instr >> 4) % 64);
        b.mode     = 2'(mode);
        for (int k = 0; k < 3; k++) fld[k] = int'((instr >> (10 + 5 * k)) % 32);
        // mode m (1..3) puts the immediate in slot m-1; fields fill the rest in order
        n = 0;
        for (int s = 0; s < 3; s++) begin
            if (mode == s + 1) slot[s] = -1;
            else begin
                slot[s] = fld[n];
                n++;
            end
        end
        for (int s = 0; s < 3; s++) begin
            if (cls != 3) begin
                if (slot[s] < 0) b.immf[s] = 1'b1;
                else b.en[s] = 32'd1 << (slot[s] % NREG);
            end
        end
        imm12  = int'(instr >> 20);
        b.immz = 32'(imm12);
        b.imm  = (imm12 >= 2048) ? 32'(imm12 - 4096) : 32'(imm12);
        return b;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input bit all);
        check("out_valid", out_valid, m_valid);
        check("zx_out_valid", zx_out_valid, m_valid);
        check("sb_busy", sb_busy, m_busy);
        if (m_valid || all) begin
            check("alu_en", out_alu_en, m_b.cls[0]);
            check("ram_en", out_ram_en, m_b.cls[1]);
            check("cond_en", out_cond_en, m_b.cls[2]);
            check("ext_en", out_ext_en, m_b.cls[3]);
            check("opcode", out_opcode, m_b.opcode);
            check("imm_mode", out_imm_mode, m_b.mode);
            check("a_en", out_a_en, m_b.en[0]);
            check("b_en", out_b_en, m_b.en[1]);
            check("c_en", out_c_en, m_b.en[2]);
            check("a_imm", out_a_imm, m_b.immf[0]);
            check("b_imm", out_b_imm, m_b.immf[1]);
            check("c_imm", out_c_imm, m_b.immf[2]);
            check("imm", out_imm, m_b.imm);
            check("zx_imm", zx_imm, m_b.immz);
        end
    endtask

    // one clock: check in_ready before the edge, advance the model, check after
    task automatic cycle();
        bundle_t     d, nb;
        bit          hz, rdy, acc, nv, all;
        logic [31:0] nbusy;
        @(negedge clk);
        d   = model_decode(in_instr);
        hz  = SB && in_valid && (((d.en[0] | d.en[1]) & m_busy) != 0);
        rdy = !rst && !flush && !hz && (!m_valid || out_ready);
        check("in_ready", in_ready, rdy);
        check("sb_busy_pre", sb_busy, m_busy);
        acc   = in_valid && rdy;
        nv    = m_valid;
        nb    = m_b;
        nbusy = m_busy;
        all   = rst;
        if (rst) begin
            nv    = 1'b0;
            nb    = '0;
            nbusy = '0;
        end else begin
            if (flush) nv = 1'b0;
            else if (acc) begin
                nv = 1'b1;
                nb = d;
            end else if (out_ready) nv = 1'b0;
            if (SB) begin
                if (wb_valid) nbusy[int'(wb_reg) % NREG] = 1'b0;
                if (flush && m_valid) nbusy = nbusy & ~m_b.en[2];
                if (acc) nbusy = nbusy | d.en[2];
            end
        end
        @(posedge clk);
        #1;
        m_valid = nv;
        m_b     = nb;
        m_busy  = nbusy;
        check_outputs(all);
    endtask

    task automatic drive(input bit v, input logic [31:0] i, input bit ordy,
                         input bit fl = 1'b0, input bit wbv = 1'b0,
                         input logic [4:0] wbr = 5'd0, input bit r = 1'b0);
        in_valid  = v;
        in_instr  = i;
        out_ready = ordy;
        flush     = fl;
        wb_valid  = wbv;
        wb_reg    = wbr;
        rst       = r;
    endtask

    task automatic do_reset();
        drive(0, 32'h0, 0, 0, 0, 0, 1);
        cycle();
        cycle();
        drive(0, 32'h0, 0);
    endtask

    initial begin
        int nvalid;
        drive(0, 32'h0, 0, 0, 0, 0, 1);

        // reset: everything zero, in_ready held low
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_imm", out_imm, 0);

        // alu mode 00
        drive(1, 32'h00720C50, 1);
        cycle();
        check("v1_alu", out_alu_en, 1);
        check("v1_opcode", out_opcode, 6'h05);
        check("v1_a_en", out_a_en, 32'h8);
        check("v1_b_en", out_b_en, 32'h10);
        check("v1_c_en", out_c_en, 32'h80);
        check("v1_imm_flags", {out_a_imm, out_b_imm, out_c_imm}, 3'b000);

        // mode 01 with all-ones immediate
        drive(1, 32'hFFF28804, 1);
        cycle();
        check("v2_a_imm", out_a_imm, 1);
        check("v2_a_en", out_a_en, 0);
        check("v2_b_en", out_b_en, 32'h4);
        check("v2_c_en", out_c_en, 32'h20);
        check("v2_imm_s", out_imm, 32'hFFFFFFFF);
        check("v2_imm_z", zx_imm, 32'h00000FFF);

        // stall for three cycles with a pending word
        drive(1, 32'h00000000, 0);
        repeat (3) cycle();
        check("stall_imm", out_imm, 32'hFFFFFFFF);
        check("stall_a_imm", out_a_imm, 1);
        check("stall_ready", in_ready, 0);

        // back-to-back, one bundle per cycle
        nvalid = 0;
        drive(1, 32'h01410400, 1); cycle(); nvalid += int'(out_valid);
        drive(1, 32'h01519031, 1); cycle(); nvalid += int'(out_valid);
        drive(1, 32'h800B180A, 1); cycle(); nvalid += int'(out_valid);
        drive(1, 32'h01410400, 1); cycle(); nvalid += int'(out_valid);
        check("b2b_count", nvalid, 4);
        drive(0, 32'h0, 1);
        cycle();

        // scoreboard interlock on r7
        do_reset();
        drive(1, 32'h00720C50, 1);
        cycle();
`ifdef DECODE_SCOREBOARD_EN
        check("sb_set7", sb_busy[7], 1);
`endif
        drive(1, 32'h00101C00, 1);
        repeat (3) cycle();
        drive(1, 32'h00101C00, 1, 0, 1, 5'd7);
        cycle();
        drive(1, 32'h00101C00, 1);
        cycle();
        drive(0, 32'h0, 1);
        cycle();

        // flush of a held writer
        do_reset();
        drive(1, 32'h00720C50, 0);
        cycle();
        drive(0, 32'h0, 0, 1);
        cycle();
        check("flush_valid", out_valid, 0);
        check("flush_sb7", sb_busy[7], 0);

        // reset in the middle of a stall
        drive(1, 32'h00720C50, 0);
        cycle();
        drive(1, 32'h01410400, 0);
        cycle();
        drive(1, 32'h01410400, 0, 0, 0, 0, 1);
        cycle();
        check("rst_mid_sb", sb_busy, 0);
        check("rst_mid_c_en", out_c_en, 0);

        // extension class leaves scoreboard alone
        drive(1, 32'h00720C50, 1);
        cycle();
        drive(1, 32'h12345673, 1);
        cycle();
        check("ext_en", out_ext_en, 1);
        check("ext_enables", {out_a_en, out_b_en, out_c_en}, 96'h0);
        check("ext_imm_flags", {out_a_imm, out_b_imm, out_c_imm}, 3'b000);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom(),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) == 0,
                  5'($urandom_range(0, 31)),
                  $urandom_range(0, 63) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
